// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clkdiv_multi tick generator.
// Optional sync_in port is enabled by defining CLKDIV_SYNC_EN.
package clkdiv_pkg;

  localparam int CLKDIV_WIDTH   = 28;
  localparam int CLKDIV_MIN_DIV = 2;

  typedef logic [CLKDIV_WIDTH-1:0] div_t;

  // Divisors below 2 cannot give a high and a low phase, so they are raised to 2.
  function automatic div_t clamp_div(input div_t d);
    return (d < div_t'(CLKDIV_MIN_DIV)) ? div_t'(CLKDIV_MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, active divisor and a single-entry pending divisor.
// The sync input is driven only when the top is built with CLKDIV_SYNC_EN.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLKDIV_MIN_DIV)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] div_n;
  logic             wrap;
  logic             swap;

  // NOTE: every signal is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    wrap  = (p == div - ONE);
    p_n   = wrap ? '0 : p + ONE;
    swap  = pending && wrap;
    div_n = swap ? pend : div;
  end

  // NOTE: state uses non-blocking assignments; the later load assignment deliberately wins.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      p       <= DEFAULT_DIV - ONE;
      div     <= DEFAULT_DIV;
      pend    <= DEFAULT_DIV;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!en || sync) begin
        // Parked at the last phase so the next running cycle starts a fresh period.
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          div     <= pend;
          p       <= pend - ONE;
          pending <= 1'b0;
        end else begin
          p <= div - ONE;
        end
      end else begin
        p       <= p_n;
        div     <= div_n;
        clk_out <= (p_n < (div_n >> 1));
        tick    <= wrap;
        if (swap) pending <= 1'b0;
      end
      if (load) begin
        pend    <= load_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider / tick generator with valid/ready divisor writes.
// Define CLKDIV_SYNC_EN to add the sync_in port that realigns all channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000),
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  output logic              cfg_clamp,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(CLKDIV_MIN_DIV);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  div_clamped;
  logic              too_small;
  logic              sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // A channel index with no matching channel leaves ready low, so it is never accepted.
  always_comb begin
    cfg_ready   = 1'b0;
    load        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
      load[i] = cfg_valid && !pending[i] && (cfg_ch == CH_W'(i));
    end
    too_small   = (cfg_div < MIN_DIV);
    div_clamped = too_small ? MIN_DIV : cfg_div;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) cfg_clamp <= 1'b0;
    else          cfg_clamp <= cfg_valid && cfg_ready && too_small;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .en       (en[g]),
      .sync     (sync),
      .load     (load[g]),
      .load_div (div_clamped),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi (DEFAULT_DIV=4); the sync scenario runs when CLKDIV_SYNC_EN is defined.
module tb_clkdiv_multi;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [3:0]  en;
  logic        sync_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [27:0] cfg_div;
  logic        cfg_clamp;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  typedef struct {
    string      nm;
    logic [3:0] mask;
    logic [3:0] c;
    logic [3:0] t;
    bit         chk_cl;
    logic       cl;
    bit         chk_rdy;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_in = ~clk_in;

  clkdiv_multi #(
    .NUM_CH      (4),
    .WIDTH       (28),
    .DEFAULT_DIV (28'd4)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .en        (en),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_clamp (cfg_clamp),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Expectations describe the outputs after the next rising edge.
  task automatic exp_ext(input string nm, input logic [3:0] m, input logic [3:0] c,
                         input logic [3:0] t, input bit chk_cl, input logic cl,
                         input bit chk_rdy, input logic rdy);
    exp_t e;
    e.nm = nm; e.mask = m; e.c = c; e.t = t;
    e.chk_cl = chk_cl; e.cl = cl; e.chk_rdy = chk_rdy; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic exp_out(input string nm, input logic [3:0] m, input logic [3:0] c,
                         input logic [3:0] t);
    exp_ext(nm, m, c, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(negedge clk_in);
  endtask

  task automatic cfg(input logic v, input logic [1:0] ch, input logic [27:0] d);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_div   = d;
  endtask

  // Release reset (if held) with all channels on: 1,1,0,0 and a tick on every 4th cycle.
  task automatic run_default(input string nm);
    for (int k = 0; k < 9; k++) begin
      nxt();
      if (k == 0) begin
        reset_n = 1'b1;
        en      = 4'hF;
      end
      exp_out(nm, 4'hF, ((k % 4) < 2) ? 4'hF : 4'h0, ((k % 4) == 0) ? 4'hF : 4'h0);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.mask != 4'h0) begin
          check({e.nm, ".clk_out"}, clk_out & e.mask, e.c & e.mask);
          check({e.nm, ".tick"}, tick & e.mask, e.t & e.mask);
        end
        if (e.chk_cl)  check({e.nm, ".cfg_clamp"}, {3'b000, cfg_clamp}, {3'b000, e.cl});
        if (e.chk_rdy) check({e.nm, ".cfg_ready"}, {3'b000, cfg_ready}, {3'b000, e.rdy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    en      = 4'h0;
    sync_in = 1'b0;
    cfg(1'b0, 2'd0, 28'd0);

    // Reset state
    nxt(); nxt(); nxt();
    exp_ext("reset", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Cycles 1..9: default divisor 4 on every channel
    run_default("t1");

    // Ch0: write 5 while p=1; current period completes first
    nxt(); exp_out("t2_pre", 4'h1, 4'h1, 4'h0);
    nxt(); cfg(1'b1, 2'd0, 28'd5); exp_ext("t2_acc", 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); cfg(1'b0, 2'd0, 28'd0); exp_ext("t2_hold", 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); exp_ext("t2_apply", 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    nxt(); exp_out("t2_run1", 4'hF, 4'hF, 4'h0);
    nxt(); exp_out("t2_run2", 4'hF, 4'h0, 4'h0);
    nxt(); exp_out("t2_run3", 4'hF, 4'h0, 4'h0);
    nxt(); exp_out("t2_run4", 4'hF, 4'hE, 4'hE);
    nxt(); exp_out("t2_run5", 4'hF, 4'hF, 4'h1);

    // Ch2: divisor 0 clamps to 2; a second write while pending is refused
    nxt(); cfg(1'b1, 2'd2, 28'd0); exp_ext("t3_clamp", 4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    nxt(); cfg(1'b1, 2'd2, 28'd7); exp_ext("t3_block", 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    nxt(); cfg(1'b0, 2'd2, 28'd0); exp_ext("t3_apply", 4'hF, 4'hE, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1);
    nxt(); exp_out("t3_run1", 4'hF, 4'hA, 4'h0);
    nxt(); exp_out("t3_run2", 4'hF, 4'h5, 4'h5);
    nxt(); exp_out("t3_run3", 4'hF, 4'h1, 4'h0);
    nxt(); exp_out("t3_run4", 4'hF, 4'hE, 4'hE);
    nxt(); exp_out("t3_run5", 4'hF, 4'hA, 4'h0);

    // Ch1: pending divisor 3 applied at once on disable; re-enable starts at phase 0
    nxt(); exp_out("t4_p2", 4'h2, 4'h0, 4'h0);
    nxt(); exp_out("t4_p3", 4'h2, 4'h0, 4'h0);
    nxt(); exp_out("t4_p0", 4'h2, 4'h2, 4'h2);
    nxt(); cfg(1'b1, 2'd1, 28'd3); exp_ext("t4_acc", 4'h2, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); cfg(1'b0, 2'd1, 28'd0); en = 4'b1101;
    exp_ext("t4_off", 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    nxt(); exp_out("t4_off2", 4'h2, 4'h0, 4'h0);
    nxt(); en = 4'hF; exp_out("t4_on", 4'h2, 4'h2, 4'h2);
    nxt(); exp_out("t4_run1", 4'h2, 4'h0, 4'h0);
    nxt(); exp_out("t4_run2", 4'h2, 4'h0, 4'h0);
    nxt(); exp_out("t4_run3", 4'h2, 4'h2, 4'h2);

    // Ch3: write 9 on a boundary cycle waits for the following boundary
    nxt(); cfg(1'b1, 2'd3, 28'd9); exp_out("t5_acc_bnd", 4'h8, 4'h8, 4'h8);
    nxt(); cfg(1'b0, 2'd3, 28'd0); exp_ext("t5_old1", 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); exp_out("t5_old2", 4'h8, 4'h0, 4'h0);
    nxt(); exp_out("t5_old3", 4'h8, 4'h0, 4'h0);
    nxt(); exp_ext("t5_new0", 4'h8, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    nxt(); exp_out("t5_new1", 4'h8, 4'h8, 4'h0);
    nxt(); exp_out("t5_new2", 4'h8, 4'h8, 4'h0);
    // Pending writes on ch0 and ch2 are then discarded by reset
    nxt(); cfg(1'b1, 2'd0, 28'd6); exp_ext("t5_new3", 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); cfg(1'b1, 2'd2, 28'd1); exp_ext("t5_new4", 4'h8, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    nxt(); reset_n = 1'b0; cfg(1'b0, 2'd0, 28'd0);
    exp_ext("t5_rst", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    nxt(); cfg(1'b0, 2'd2, 28'd0); exp_ext("t5_rst2", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_default("t5_restart");

`ifdef CLKDIV_SYNC_EN
    // Ch0 div 3 and ch1 div 5 out of phase, then a sync pulse realigns them
    nxt(); en = 4'h0; cfg(1'b1, 2'd0, 28'd3); exp_out("t6_off", 4'hF, 4'h0, 4'h0);
    nxt(); cfg(1'b1, 2'd1, 28'd5); exp_out("t6_off2", 4'hF, 4'h0, 4'h0);
    nxt(); cfg(1'b0, 2'd0, 28'd0); exp_out("t6_off3", 4'hF, 4'h0, 4'h0);
    nxt(); en = 4'b0001; exp_out("t6_ch0", 4'hF, 4'h1, 4'h1);
    nxt(); en = 4'b0011; exp_out("t6_ch1", 4'hF, 4'h2, 4'h2);
    nxt(); exp_out("t6_a", 4'hF, 4'h2, 4'h0);
    nxt(); exp_out("t6_b", 4'hF, 4'h1, 4'h1);
    nxt(); sync_in = 1'b1; exp_out("t6_sync", 4'hF, 4'h0, 4'h0);
    nxt(); sync_in = 1'b0; exp_out("t6_align", 4'hF, 4'h3, 4'h3);
    nxt(); exp_out("t6_c", 4'hF, 4'h2, 4'h0);
    nxt(); exp_out("t6_d", 4'hF, 4'h0, 4'h0);
    nxt(); exp_out("t6_e", 4'hF, 4'h1, 4'h1);
`endif

    @(posedge clk_in);
    #5;
    check("scoreboard_drain", 4'(q.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
